// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - access-size encodings and FSM state type for the handshaked data memory
package dmem_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_align.sv
// rtl/dmem_align.sv - byte-lane steering, alignment checks and load extension
module dmem_align
    import dmem_pkg::*;
(
    input  logic [2:0]  dm_ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_lane_data,
    output logic        misalign,
    output logic        illegal,
    output logic [31:0] rd_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lanes picked out of the raw word by the low address bits
    assign sel_byte = rd_word[{addr_lo, 3'b000} +: 8];
    assign sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    // Store data is replicated across lanes so the byte-enable alone selects the target
    always_comb begin
        byte_en      = 4'b0000;
        wr_lane_data = 32'h0;
        misalign     = 1'b0;
        illegal      = 1'b0;
        rd_data      = 32'h0;
        case (dm_ctrl)
            DM_B, DM_BU: begin
                byte_en      = 4'b0001 << addr_lo;
                wr_lane_data = {4{wr_data[7:0]}};
                rd_data      = (dm_ctrl == DM_B) ? {{24{sel_byte[7]}}, sel_byte}
                                                 : {24'h0, sel_byte};
            end
            DM_H, DM_HU: begin
                byte_en      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_lane_data = {2{wr_data[15:0]}};
                misalign     = addr_lo[0];
                rd_data      = (dm_ctrl == DM_H) ? {{16{sel_half[15]}}, sel_half}
                                                 : {16'h0, sel_half};
            end
            DM_W: begin
                byte_en      = 4'b1111;
                wr_lane_data = wr_data;
                misalign     = (addr_lo != 2'b00);
                rd_data      = rd_word;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - handshaked load/store data memory with configurable wait states
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        DMWR,
    input  logic [2:0]  DMCtrl,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] DataRd,
    output logic        rsp_err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [2:0]  ctrl_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        accept;
    logic        do_access;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lane_data;
    logic [31:0]   load_data;
    logic          misalign;
    logic          illegal;
    logic          out_of_range;
    logic          store_unsigned;
    logic          acc_err;

    assign word_idx       = addr_q[AW+1:2];
    assign rd_word        = mem[word_idx];
    assign out_of_range   = ({1'b0, addr_q} >= BYTE_LIMIT);
    assign store_unsigned = wr_q && ((ctrl_q == DM_BU) || (ctrl_q == DM_HU));
    assign acc_err        = out_of_range || misalign || illegal || store_unsigned;

    dmem_align u_align (
        .dm_ctrl      (ctrl_q),
        .addr_lo      (addr_q[1:0]),
        .wr_data      (data_q),
        .rd_word      (rd_word),
        .byte_en      (byte_en),
        .wr_lane_data (wr_lane_data),
        .misalign     (misalign),
        .illegal      (illegal),
        .rd_data      (load_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; the access fires on the last BUSY cycle
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture and wait-state countdown; inputs are ignored after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 4'd0;
            wr_q   <= 1'b0;
            ctrl_q <= 3'b000;
            addr_q <= 32'h0;
            data_q <= 32'h0;
        end else if (accept) begin
            cnt_q  <= 4'(WAIT_CYCLES);
            wr_q   <= DMWR;
            ctrl_q <= DMCtrl;
            addr_q <= Address;
            data_q <= DataWr;
        end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Response registers stay put through RESP until the consumer takes them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DataRd  <= 32'h0;
            rsp_err <= 1'b0;
        end else if (do_access) begin
            DataRd  <= (acc_err || wr_q) ? 32'h0 : load_data;
            rsp_err <= acc_err;
        end
    end

    // Byte-enabled store into the unreset array, only on a clean access edge
    always_ff @(posedge clk) begin
        if (do_access && wr_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lane_data[8*b +: 8];
                end
            end
        end
    end

endmodule
